// File: rtl/pudiannao_pkg.sv
// Shared result-kind encoding, write-back FSM states and result length decode.
package pudiannao_pkg;

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_COUNTER = 3'b001;
    localparam logic [2:0] SEL_ADDER   = 3'b010;
    localparam logic [2:0] SEL_MULT    = 3'b011;
    localparam logic [2:0] SEL_ACC     = 3'b100;
    localparam logic [2:0] SEL_NONLIN  = 3'b101;
    localparam logic [2:0] SEL_KSORT   = 3'b110;
    localparam logic [2:0] SEL_RSVD    = 3'b111;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} wb_state_t;

    // Number of 32-bit words a result of this kind occupies; 0 marks an illegal kind.
    function automatic int unsigned sel_len(input logic [2:0] sel,
                                            input int unsigned lanes,
                                            input int unsigned k);
        case (sel)
            SEL_COUNTER, SEL_ADDER, SEL_MULT: sel_len = lanes;
            SEL_ACC, SEL_NONLIN:              sel_len = 1;
            SEL_KSORT:                        sel_len = k;
            default:                          sel_len = 0;
        endcase
    endfunction

endpackage

// File: rtl/wb_word_select.sv
// Picks word idx of the latched result and applies the 16-bit datapath masking.
module wb_word_select
    import pudiannao_pkg::*;
#(
    parameter int K     = 20,
    parameter int LANES = 16
) (
    input  logic [2:0]                 sel,
    input  logic [$clog2(K)-1:0]       idx,
    input  logic [31:0]                scalar,
    input  logic [LANES-1:0][31:0]     vector,
    input  logic [K-1:0][31:0]         ksort,
    output logic [31:0]                word
);

    localparam int LANE_W = $clog2(LANES);

    // Adder/multiplier lanes are 16 bits wide, so their upper half is never meaningful.
    always_comb begin
        word = 32'h0;
        case (sel)
            SEL_COUNTER:         word = vector[idx[LANE_W-1:0]];
            SEL_ADDER, SEL_MULT: word = {16'h0, vector[idx[LANE_W-1:0]][15:0]};
            SEL_ACC, SEL_NONLIN: word = scalar;
            SEL_KSORT:           word = ksort[idx];
            default:             word = 32'h0;
        endcase
    end

endmodule

// File: rtl/fu_writeback.sv
// Functional-unit write-back: captures one selected result, serialises it into
// 32-bit words on a granted write port, and walks a wrapping output region.
module fu_writeback
    import pudiannao_pkg::*;
#(
    parameter int K      = 20,
    parameter int LANES  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 sel,
    input  logic [31:0]                in_scalar,
    input  logic [LANES-1:0][31:0]     in_vector,
    input  logic [K-1:0][31:0]         in_ksort,
    input  logic                       cfg_load,
    input  logic [ADDR_W-1:0]          cfg_base,
    input  logic [ADDR_W-1:0]          cfg_words,
    output logic                       wr_en,
    input  logic                       wr_gnt,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [31:0]                wr_data,
    output logic                       done,
    output logic                       err
);

    localparam int IDX_W = $clog2(K);

    wb_state_t               state;
    logic [2:0]              sel_q;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        len_m1;
    logic [31:0]             scalar_q;
    logic [LANES-1:0][31:0]  vector_q;
    logic [K-1:0][31:0]      ksort_q;
    logic [ADDR_W-1:0]       base;
    logic [ADDR_W-1:0]       words;
    logic [ADDR_W-1:0]       ptr;
    logic [ADDR_W-1:0]       last_addr;
    logic [31:0]             word;
    logic                    accept;
    logic                    legal;

    assign accept    = in_valid && in_ready;
    assign legal     = sel_len(sel, LANES, K) != 0;
    assign last_addr = base + words - ADDR_W'(1);
    assign wr_addr   = ptr;
    // Data is only meaningful while a write is pending; keep the bus quiet otherwise.
    assign wr_data   = wr_en ? word : 32'h0;

    wb_word_select #(.K(K), .LANES(LANES)) u_word_select (
        .sel    (sel_q),
        .idx    (idx),
        .scalar (scalar_q),
        .vector (vector_q),
        .ksort  (ksort_q),
        .word   (word)
    );

    // Payload capture: sampled only on a legal accept, ignored afterwards.
    always_ff @(posedge clk) begin
        if (accept && legal) begin
            sel_q    <= sel;
            scalar_q <= in_scalar;
            vector_q <= in_vector;
            ksort_q  <= in_ksort;
        end
    end

    // Control FSM with registered handshake/status outputs and the region pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            len_m1   <= '0;
            base     <= '0;
            words    <= ADDR_W'(1);
            ptr      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A coincident accept writes from the freshly loaded base.
                    if (cfg_load) begin
                        base  <= cfg_base;
                        words <= cfg_words;
                        ptr   <= cfg_base;
                    end
                    if (accept) begin
                        if (legal) begin
                            idx      <= '0;
                            len_m1   <= IDX_W'(sel_len(sel, LANES, K) - 1);
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                            wr_en    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_gnt) begin
                        idx <= idx + IDX_W'(1);
                        ptr <= (ptr == last_addr) ? base : ptr + ADDR_W'(1);
                        if (idx == len_m1) begin
                            state <= DONE;
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    wr_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_writeback.sv
// Scoreboard bench for fu_writeback: stimulus pushes expected writes/pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_fu_writeback;

    localparam int K = 20, LANES = 16, ADDR_W = 10;
    localparam logic [1:0] E_WR = 2'd0, E_DONE = 2'd1, E_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [2:0]              sel = 3'b0;
    logic [31:0]             in_scalar = 32'h0;
    logic [LANES-1:0][31:0]  in_vector = '0;
    logic [K-1:0][31:0]      in_ksort = '0;
    logic                    cfg_load = 1'b0;
    logic [ADDR_W-1:0]       cfg_base = '0;
    logic [ADDR_W-1:0]       cfg_words = '0;
    logic                    wr_en;
    logic                    wr_gnt = 1'b1;
    logic [ADDR_W-1:0]       wr_addr;
    logic [31:0]             wr_data;
    logic                    done;
    logic                    err;

    int          nvec = 0;
    int          nmis = 0;
    exp_t        q[$];
    logic [31:0] exp_words [0:K-1];
    logic [9:0]  m_base = 0, m_words = 1, m_ptr = 0;
    bit          gnt_tog = 1'b0;
    bit          hold_v = 1'b0;
    logic [9:0]  hold_a;
    logic [31:0] hold_d;

    fu_writeback #(.K(K), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .in_scalar(in_scalar), .in_vector(in_vector), .in_ksort(in_ksort),
        .cfg_load(cfg_load), .cfg_base(cfg_base), .cfg_words(cfg_words),
        .wr_en(wr_en), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] nxt(input logic [9:0] p);
        return (p == m_base + m_words - 10'd1) ? m_base : p + 10'd1;
    endfunction

    // Grant driver: held high, or toggling every cycle when gnt_tog is set.
    initial forever begin
        @(posedge clk); #1;
        wr_gnt = gnt_tog ? ~wr_gnt : 1'b1;
    end

    // Monitor: pops the scoreboard on every granted write, done and err pulse.
    always @(negedge clk) begin
        exp_t e;
        if (hold_v && wr_en) begin
            chk("hold_addr", wr_addr, hold_a);
            chk("hold_data", wr_data, hold_d);
        end
        hold_v = wr_en && !wr_gnt;
        hold_a = wr_addr;
        hold_d = wr_data;
        if (wr_en && wr_gnt) begin
            if (q.size() == 0 || q[0].kind != E_WR) begin
                nvec++; nmis++;
                $display("FAIL unexpected_write: got addr %h data %h, want no write", wr_addr, wr_data);
                if (q.size() != 0) void'(q.pop_front());
            end else begin
                e = q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
        end
        if (done) begin
            if (q.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_done: got done=1, want 0");
            end else begin
                e = q.pop_front();
                chk("done_kind", e.kind, E_DONE);
            end
        end
        if (err) begin
            if (q.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_err: got err=1, want 0");
            end else begin
                e = q.pop_front();
                chk("err_kind", e.kind, E_ERR);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (!in_ready) begin
            nvec++; nmis++;
            $display("FAIL idle_timeout: got in_ready=0, want 1");
        end
    endtask

    task automatic cfg(input logic [9:0] b, input logic [9:0] w);
        wait_idle();
        cfg_load = 1'b1; cfg_base = b; cfg_words = w;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        m_base = b; m_words = w; m_ptr = b;
    endtask

    // Issue one result; expected words come from exp_words[0..n-1].
    task automatic send(input logic [2:0] s, input int n, input bit do_cfg,
                        input logic [9:0] cb, input logic [9:0] cw,
                        input bit chk_lat, input bit mid_cfg);
        int lat;
        wait_idle();
        if (do_cfg) begin
            cfg_load = 1'b1; cfg_base = cb; cfg_words = cw;
            m_base = cb; m_words = cw; m_ptr = cb;
        end
        sel = s; in_valid = 1'b1;
        if (s == 3'b000 || s == 3'b111) begin
            q.push_back('{kind: E_ERR, addr: 10'h0, data: 32'h0});
        end else begin
            for (int i = 0; i < n; i++) begin
                q.push_back('{kind: E_WR, addr: m_ptr, data: exp_words[i]});
                m_ptr = nxt(m_ptr);
            end
            q.push_back('{kind: E_DONE, addr: 10'h0, data: 32'h0});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_load = 1'b0;
        in_scalar = 32'hDEAD_BEEF;
        for (int i = 0; i < LANES; i++) in_vector[i] = 32'h5A5A_0000 + i;
        for (int i = 0; i < K; i++) in_ksort[i] = 32'h0BAD_0000 + i;
        if (s == 3'b000 || s == 3'b111) begin
            chk("illegal_in_ready", in_ready, 1'b1);
            for (int i = 0; i < 4; i++) begin
                chk("illegal_no_wr_en", wr_en, 1'b0);
                @(posedge clk); #1;
            end
            return;
        end
        if (mid_cfg) begin
            cfg_load = 1'b1; cfg_base = 10'h3FF; cfg_words = 10'd2;
            @(posedge clk); #1;
            cfg_load = 1'b0;
        end
        lat = mid_cfg ? 1 : 0;
        while (lat <= 200) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        if (lat > 200) begin
            nvec++; nmis++;
            $display("FAIL done_timeout: got no done, want done within 200 cycles");
        end else if (chk_lat) begin
            chk("done_latency", lat, n + 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 10'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);

        // 1: full-width vector into 0x010, latency checked
        cfg(10'h010, 10'd64);
        for (int i = 0; i < LANES; i++) begin
            in_vector[i] = 32'hA000_0000 + i;
            exp_words[i] = 32'hA000_0000 + i;
        end
        send(3'b001, LANES, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);

        // 2: 16-bit adder result, upper half masked; cfg_load during drain ignored
        for (int i = 0; i < LANES; i++) begin
            in_vector[i] = 32'hFFFF_8000 | i;
            exp_words[i] = 32'h0000_8000 | i;
        end
        send(3'b010, LANES, 1'b0, 10'h0, 10'h0, 1'b0, 1'b1);
        in_scalar = 32'h99; exp_words[0] = 32'h99;
        send(3'b100, 1, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);

        // 3: wrapping region of 4 words at 0x100
        cfg(10'h100, 10'd4);
        in_scalar = 32'h11; exp_words[0] = 32'h11;
        send(3'b100, 1, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);
        in_scalar = 32'h22; exp_words[0] = 32'h22;
        send(3'b101, 1, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);
        for (int i = 0; i < LANES; i++) begin
            in_vector[i] = 32'h1234_0000 + i;
            exp_words[i] = i;
        end
        send(3'b011, LANES, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);

        // 4: k-sort list with toggling grant
        cfg(10'h300, 10'd32);
        for (int i = 0; i < K; i++) begin
            in_ksort[i]  = 32'hC000_0000 | (i << 8) | i;
            exp_words[i] = 32'hC000_0000 | (i << 8) | i;
        end
        gnt_tog = 1'b1;
        send(3'b110, K, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
        gnt_tog = 1'b0;
        @(posedge clk); #1;

        // 5: illegal kind, then cfg_load coincident with an accept
        send(3'b111, 0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0);
        in_scalar = 32'h55; exp_words[0] = 32'h55;
        send(3'b100, 1, 1'b1, 10'h200, 10'd8, 1'b1, 1'b0);

        // 6: reset in the middle of a vector drain
        wait_idle();
        for (int i = 0; i < LANES; i++) in_vector[i] = 32'hB000_0000 + i;
        sel = 3'b001; in_valid = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            q.push_back('{kind: E_WR, addr: m_ptr, data: 32'hB000_0000 + i});
            m_ptr = nxt(m_ptr);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_wr_addr", wr_addr, 10'h0);
        chk("midrst_consumed", q.size(), LANES - 6);
        q.delete();
        m_base = 0; m_words = 1; m_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        in_scalar = 32'h77; exp_words[0] = 32'h77;
        send(3'b100, 1, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_left", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
